// File: rtl/ste_avg_pkg.sv
// Shared types and default constants for the averager sequencing controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package ste_avg_pkg;

  // Controller state; the encoding is visible on state_o for debug.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    SETTLE = 2'd2,
    AVG    = 2'd3
  } avg_state_t;

  localparam int AVG_BLANK_N  = 2;
  localparam int AVG_SETTLE_N = 30;
  localparam int AVG_PIPE_LAT = 2;

endpackage

// File: rtl/ste_valid_pipe.sv
// Delay line for the sample valid strobe, matching the averager datapath latency.
// Latency: DEPTH cycles from din to dout; flush zeroes every stage on the next edge.
// Backpressure: none; one strobe per cycle is always accepted.
// Ports: clk/rst (async, active-high), flush (sync clear), din (strobe in), dout (delayed strobe).
module ste_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else if (flush) begin
      stage <= '0;
    end else begin
      // Shift form works for DEPTH = 1 as well as deeper lines.
      stage <= (stage << 1) | DEPTH'(din);
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/ste_avg_ctrl.sv
// Sequences clear/enable of the IIR averager around range/mode/request changes and flags valid, settled results.
// Latency: outputs registered; clear pulse 1 cycle after a detected change, dout_valid PIPE_LAT+1 cycles after a strobe.
// Backpressure: none; sample strobes are counted or dropped, never stalled.
// Ports: clk, rst (async, active-high); sample_valid_i, avg_req_i, range_i, mode_i in;
//        avg_clr_o, avg_en_o, dout_valid_o, settled_o, state_o out.
module ste_avg_ctrl
  import ste_avg_pkg::*;
#(
  parameter int BLANK_N  = AVG_BLANK_N,
  parameter int SETTLE_N = AVG_SETTLE_N,
  parameter int PIPE_LAT = AVG_PIPE_LAT,
  parameter int CNT_W    = 8,
  parameter int RANGE_W  = 3,
  parameter int MODE_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid_i,
  input  logic               avg_req_i,
  input  logic [RANGE_W-1:0] range_i,
  input  logic [MODE_W-1:0]  mode_i,
  output logic               avg_clr_o,
  output logic               avg_en_o,
  output logic               dout_valid_o,
  output logic               settled_o,
  output logic [1:0]         state_o
);

  localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_N);
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE_N);

  logic [RANGE_W-1:0] range_q;
  logic [MODE_W-1:0]  mode_q;
  logic               req_q;
  avg_state_t         state_q;
  avg_state_t         state_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               change;
  logic               req_rise;
  logic               req_fall;
  logic               clr_evt;
  logic               flush;
  logic               ins;
  logic               pipe_out;

  assign change   = (range_i != range_q) || (mode_i != mode_q);
  assign req_rise = avg_req_i & ~req_q;
  assign req_fall = ~avg_req_i & req_q;
  // A change with the request low only pulses clear; it does not restart sequencing.
  assign clr_evt  = avg_req_i & (change | req_rise);
  assign flush    = clr_evt | req_fall;
  // Counter saturates instead of wrapping so a long AVG run cannot alias back.
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Strobes coinciding with a change belong to the old configuration; blanked
  // samples never produce a result.
  assign ins = sample_valid_i & ~change & ~flush & (state_q != BLANK);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    if (req_fall) begin
      // Drop has priority over any simultaneous change.
      state_nxt = IDLE;
    end else if (clr_evt) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
    end else if (!avg_req_i) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        BLANK: begin
          if (BLANK_N == 0) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
          end else if (sample_valid_i) begin
            if (cnt_inc >= BLANK_C) begin
              state_nxt = SETTLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end
        end
        SETTLE: begin
          if (sample_valid_i) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc >= SETTLE_C) begin
              state_nxt = AVG;
            end
          end
        end
        AVG: begin
          if (sample_valid_i) begin
            cnt_nxt = cnt_inc;
          end
        end
        IDLE: begin
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and all outputs registered together; level outputs decode the next state
  // so they line up with state_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      range_q      <= '0;
      mode_q       <= '0;
      req_q        <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      avg_clr_o    <= 1'b0;
      avg_en_o     <= 1'b0;
      settled_o    <= 1'b1;
      dout_valid_o <= 1'b0;
    end else begin
      range_q      <= range_i;
      mode_q       <= mode_i;
      req_q        <= avg_req_i;
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      avg_clr_o    <= change | req_rise;
      avg_en_o     <= (state_nxt == SETTLE) || (state_nxt == AVG);
      settled_o    <= (state_nxt == IDLE) || (state_nxt == AVG);
      // The last pipe stage is discarded by a flush in the same cycle.
      dout_valid_o <= pipe_out & ~flush & (state_nxt != BLANK);
    end
  end

  assign state_o = state_q;

  ste_valid_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_valid_pipe (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .din   (ins),
    .dout  (pipe_out)
  );

endmodule

// File: tb/tb_ste_avg_ctrl.sv
// Directed bench for ste_avg_ctrl: expected dout_valid and clear pulse cycles
// are queued by the stimulus and matched by an independent monitor.
module tb_ste_avg_ctrl;

  logic       clk;
  logic       rst;
  logic       sample_valid_i;
  logic       avg_req_i;
  logic [2:0] range_i;
  logic [1:0] mode_i;
  logic       avg_clr_o;
  logic       avg_en_o;
  logic       dout_valid_o;
  logic       settled_o;
  logic [1:0] state_o;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int dv_seen = 0;
  int dv_base;
  int dv_q[$];
  int clr_q[$];

  ste_avg_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .sample_valid_i (sample_valid_i),
    .avg_req_i      (avg_req_i),
    .range_i        (range_i),
    .mode_i         (mode_i),
    .avg_clr_o      (avg_clr_o),
    .avg_en_o       (avg_en_o),
    .dout_valid_o   (dout_valid_o),
    .settled_o      (settled_o),
    .state_o        (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe, then idle to a 4-cycle spacing; push marks a strobe that must yield a result.
  task automatic strobe(input bit push);
    sample_valid_i = 1'b1;
    if (push) dv_q.push_back(cyc + 3);
    tick();
    sample_valid_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic chk_levels(input string name, input int st, input int en, input int stl);
    chk({name, "_state"},   int'(state_o),   st);
    chk({name, "_en"},      int'(avg_en_o),  en);
    chk({name, "_settled"}, int'(settled_o), stl);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge clk) begin
    int e;
    if (dout_valid_o) begin
      dv_seen++;
      if (dv_q.size() == 0) chk("dout_valid_unexpected", int'(dout_valid_o), 0);
      else begin
        e = dv_q.pop_front();
        chk("dout_valid_cycle", cyc, e);
      end
    end
    while (dv_q.size() > 0 && dv_q[0] < cyc) begin
      e = dv_q.pop_front();
      chk("dout_valid_missing_at", cyc, e);
    end
    if (avg_clr_o) begin
      if (clr_q.size() == 0) chk("avg_clr_unexpected", int'(avg_clr_o), 0);
      else begin
        e = clr_q.pop_front();
        chk("avg_clr_cycle", cyc, e);
      end
    end
    while (clr_q.size() > 0 && clr_q[0] < cyc) begin
      e = clr_q.pop_front();
      chk("avg_clr_missing_at", cyc, e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sample_valid_i = 1'b0;
    avg_req_i = 1'b0;
    range_i = 3'd0;
    mode_i = 2'd0;
    repeat (2) tick();
    chk("rst_clr", int'(avg_clr_o), 0);
    chk("rst_dv", int'(dout_valid_o), 0);
    chk_levels("rst", 0, 0, 1);
    rst = 1'b0;
    tick();

    // Pass-through in IDLE: three strobes, no clear.
    for (int i = 0; i < 3; i++) strobe(1'b1);
    chk_levels("idle", 0, 0, 1);
    chk("idle_dv_count", dv_seen, 3);

    // Range change with request low: clear pulse only.
    range_i = 3'd2;
    clr_q.push_back(cyc + 1);
    tick();
    tick();
    chk_levels("idle_chg", 0, 0, 1);

    // Request rise: clear, BLANK 2, SETTLE 30, then AVG.
    dv_base = dv_seen;
    avg_req_i = 1'b1;
    clr_q.push_back(cyc + 1);
    tick();
    chk_levels("req_rise", 1, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      strobe(i > 2);
      if (i == 1)  chk_levels("blank1", 1, 0, 0);
      if (i == 2)  chk_levels("settle_entry", 2, 1, 0);
      if (i == 31) chk_levels("settle_last", 2, 1, 0);
      if (i == 32) chk_levels("avg_entry", 3, 1, 1);
    end
    chk("avg_dv_count", dv_seen - dv_base, 38);

    // In AVG: a strobe, then strobe plus range change; first result flushed, second dropped.
    sample_valid_i = 1'b1;
    tick();
    range_i = 3'd3;
    clr_q.push_back(cyc + 1);
    tick();
    sample_valid_i = 1'b0;
    chk_levels("chg_in_avg", 1, 0, 0);
    repeat (4) tick();
    chk("flush_dv_count", dv_seen - dv_base, 38);
    strobe(1'b0);
    chk_levels("reblank1", 1, 0, 0);
    strobe(1'b0);
    chk_levels("reblank2", 2, 1, 0);

    // Drop request in SETTLE at count 15.
    for (int i = 0; i < 15; i++) strobe(1'b1);
    chk_levels("settle15", 2, 1, 0);
    avg_req_i = 1'b0;
    tick();
    chk_levels("drop", 0, 0, 1);
    repeat (2) tick();

    // Back to AVG, then two consecutive mode changes.
    avg_req_i = 1'b1;
    clr_q.push_back(cyc + 1);
    tick();
    strobe(1'b0);
    strobe(1'b0);
    for (int i = 0; i < 30; i++) strobe(1'b1);
    chk_levels("avg2", 3, 1, 1);
    mode_i = 2'd1;
    clr_q.push_back(cyc + 1);
    tick();
    chk_levels("mchg1", 1, 0, 0);
    mode_i = 2'd2;
    clr_q.push_back(cyc + 1);
    tick();
    chk_levels("mchg2", 1, 0, 0);
    strobe(1'b0);
    chk_levels("mchg_blank1", 1, 0, 0);
    strobe(1'b0);
    chk_levels("mchg_settle", 2, 1, 0);

    // Async reset mid-SETTLE, checked before the next clock edge.
    for (int i = 0; i < 3; i++) strobe(1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_clr", int'(avg_clr_o), 0);
    chk("arst_dv", int'(dout_valid_o), 0);
    chk_levels("arst", 0, 0, 1);
    avg_req_i = 1'b0;
    tick();
    tick();
    // Release with range/mode nonzero: seen as a change on the first edge.
    rst = 1'b0;
    clr_q.push_back(cyc + 1);
    tick();
    tick();
    chk_levels("post_rst", 0, 0, 1);
    repeat (5) tick();

    chk("dv_pending", dv_q.size(), 0);
    chk("clr_pending", clr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ste_avg_ctrl.md
# ste_avg_ctrl

Sequencing controller for the 1st-order IIR averager in the multimeter measurement path. Watches the ADC sample strobe, the measurement range and the mode selection. Drives the averager's clear and enable inputs so that, after any configuration change, the IIR state is flushed, transient samples are blanked and a settling window elapses before averaged results are flagged valid to the display and readout logic.

## Interface
- `BLANK_N`, default 2: samples discarded after a clear, before averaging starts.
- `SETTLE_N`, default 30: averaged samples required before results are flagged settled; matches the IIR time constant of 1/30.
- `PIPE_LAT`, default 2: clock cycles from a sample entering the averager until its result appears on the averager output.
- `CNT_W`, default 8: sample counter width; must satisfy 2^CNT_W > max(`BLANK_N`, `SETTLE_N`).
- `RANGE_W`, default 3 / `MODE_W`, default 2: configuration field widths.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `sample_valid_i` input 1: one-cycle strobe when a new ADC sample is presented to the averager.
- `avg_req_i` input 1: user averaging request (level).
- `range_i` input `RANGE_W`: active measurement range.
- `mode_i` input `MODE_W`: active measurement mode.
- `avg_clr_o` output 1: one-cycle clear pulse to the averager.
- `avg_en_o` output 1: averager enable (level).
- `dout_valid_o` output 1: one-cycle strobe; the averager output holds a result belonging to the current configuration.
- `settled_o` output 1: the result on the averager output is fully settled.
- `state_o` output 2: current FSM state, for debug.

## Operation
- FSM states, with `state_o` encoding:
  - `IDLE` = 0: pass-through.
  - `BLANK` = 1.
  - `SETTLE` = 2.
  - `AVG` = 3.
- Config change detection:
  - `range_i` and `mode_i` are registered every cycle.
  - A change is flagged when either input differs from its registered copy.
  - Reset loads the registers with 0.
- Clear event:
  - Caused by a config change while `avg_req_i`=1, or by a rising edge of `avg_req_i`.
  - Effect: `avg_clr_o` pulses, the sample counter is set to 0, the FSM goes to `BLANK`, and the valid pipeline is flushed.
- `IDLE`:
  - `avg_en_o`=0 and `settled_o`=1.
  - A config change pulses `avg_clr_o` and the FSM stays in `IDLE`.
  - `dout_valid_o` follows delayed strobes.
- `BLANK`:
  - `avg_en_o`=0 and `settled_o`=0.
  - The counter counts accepted strobes. After the `BLANK_N`-th strobe, the counter resets and the FSM goes to `SETTLE`.
  - `dout_valid_o` is suppressed.
  - If `BLANK_N`=0, the FSM goes directly to `SETTLE` on the cycle after the clear.
- `SETTLE`:
  - `avg_en_o`=1 and `settled_o`=0.
  - The counter counts strobes. On the `SETTLE_N`-th strobe the FSM goes to `AVG`.
  - `dout_valid_o` follows delayed strobes (unsettled results).
- `AVG`:
  - `avg_en_o`=1 and `settled_o`=1.
  - `dout_valid_o` follows delayed strobes.
- `avg_req_i` falling edge, from any state: go to `IDLE`, no clear pulse, flush the valid pipeline.
- Counter: saturates at all-ones. It never wraps.
- Valid pipeline:
  - A `PIPE_LAT`-deep shift register of `sample_valid_i`.
  - A clear event or a request drop zeroes all stages in the same cycle.
  - Strobes entering during `BLANK` are not inserted.

## Timing
- All outputs are registered. Inputs are sampled on edge k; responses appear after edge k+1.
- Reset values:
  - `avg_clr_o`=0, `avg_en_o`=0, `dout_valid_o`=0.
  - `settled_o`=1, `state_o`=0 (`IDLE`).
  - Counter 0, pipeline 0.
- `avg_clr_o` goes high exactly one cycle after the change or request edge is detected, and lasts 1 cycle.
- `dout_valid_o` latency: `PIPE_LAT`+1 cycles after the accepted `sample_valid_i`.
- Simultaneous events:
  - Config change and strobe in the same cycle: the change wins, and the strobe is not counted or inserted.
  - Request drop and config change in the same cycle: drop wins, and the FSM goes to `IDLE` with a clear pulse due to the change.
  - Back-to-back config changes: each one pulses clear and restarts `BLANK` from count 0.
  - Strobes on consecutive cycles are all counted.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously. After release, a nonzero `range_i` or `mode_i` registers as a change on the first edge.

## Structure
- Shared package `ste_avg_pkg` holds:
  - `avg_state_t`, an enum with the encoding above.
  - Default constants `AVG_BLANK_N`=2, `AVG_SETTLE_N`=30, `AVG_PIPE_LAT`=2.
- Sub-module `ste_valid_pipe`: parameterised shift-register delay line for the valid strobe, with a synchronous flush input. Everything else lives in `ste_avg_ctrl`.

## Test plan
- Reset release with `range_i`=0, `mode_i`=0 and `avg_req_i`=0; send 3 strobes.
  - `state_o`=0, `avg_en_o`=0, and no `avg_clr_o` pulse.
  - `dout_valid_o` pulses 3 times, each 3 cycles after its strobe.
- Raise `avg_req_i`, then send 40 strobes spaced 4 cycles apart.
  - One `avg_clr_o` pulse, then `BLANK` for 2 strobes with no `dout_valid_o`.
  - `SETTLE` for 30 strobes with `avg_en_o`=1 and `settled_o`=0.
  - Then `AVG` with `settled_o`=1; 38 `dout_valid_o` pulses in total.
- In `AVG`, change `range_i` 2→3 in the same cycle as a strobe.
  - The strobe is ignored, `avg_clr_o` pulses once, and the FSM returns to `BLANK`.
  - Pending `dout_valid_o` pulses are flushed.
- In `SETTLE` at count 15, drop `avg_req_i`.
  - Next cycle: `state_o`=0, `avg_en_o`=0, `settled_o`=1, and no clear pulse.
- Change `mode_i` on two consecutive cycles while in `AVG`.
  - Two `avg_clr_o` pulses; the counter is 0 after each, and the FSM stays in `BLANK`.
- Assert `rst` asynchronously mid-`SETTLE`.
  - All outputs reach reset values before the next clock edge.
